// File: rtl/reg_file_scoreboard_pkg.sv
// Shared defaults and helpers for the register file and its pending-write scoreboard.
// No logic of its own; latency and backpressure are defined by the modules that import it.
// The writable() helper keeps the hardwired-zero rule in one place for data and scoreboard paths.
package reg_file_scoreboard_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 5;
    localparam int DEPTH      = 2 ** ADDR_W_DEF;

    // Register 0 is read-only when the hardwired zero register is enabled.
    function automatic logic writable(input logic [31:0] addr, input logic zero_reg);
        return !(zero_reg && (addr == 32'd0));
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on writeback, flushable.
// pending/pending_cnt are registered (visible the cycle after the event); issue_waw is combinational.
// No backpressure: every issue, write and flush is accepted in the cycle it is presented.
module rf_scoreboard
    import reg_file_scoreboard_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic                   issue_en,
    input  logic [ADDR_W-1:0]      issue_addr,
    input  logic                   flush,
    output logic [2**ADDR_W-1:0]   pending,
    output logic [ADDR_W:0]        pending_cnt,
    output logic                   issue_waw
);

    localparam int CNT_W = ADDR_W + 1;

    logic                  set_ok;
    logic                  clr_ok;
    logic                  inc;
    logic                  dec;
    logic [2**ADDR_W-1:0]  pending_nxt;
    logic [CNT_W-1:0]      cnt_nxt;

    always_comb begin
        set_ok      = issue_en && writable(32'(issue_addr), ZERO_REG != 0);
        // A same-address issue beats the writeback: the new producer owns the register.
        clr_ok      = wr_en && writable(32'(wr_addr), ZERO_REG != 0)
                      && !(set_ok && (issue_addr == wr_addr));
        inc         = set_ok && !pending[issue_addr];
        dec         = clr_ok && pending[wr_addr];
        pending_nxt = pending;
        cnt_nxt     = pending_cnt;
        if (flush) begin
            pending_nxt = '0;
            cnt_nxt     = '0;
        end else begin
            if (set_ok) pending_nxt[issue_addr] = 1'b1;
            if (clr_ok) pending_nxt[wr_addr]    = 1'b0;
            if (inc && !dec) cnt_nxt = pending_cnt + CNT_W'(1);
            else if (dec && !inc) cnt_nxt = pending_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending     <= '0;
            pending_cnt <= '0;
        end else begin
            pending     <= pending_nxt;
            pending_cnt <= cnt_nxt;
        end
    end

    assign issue_waw = !reset && issue_en && pending[issue_addr];

endmodule

// File: rtl/reg_file_scoreboard.sv
// Multi-read-port register file with write-to-read bypass, optional zero register and hazard scoreboard.
// Reads are combinational (zero latency); writes and pending bits update on the rising clock edge.
// No backpressure: stall/rd_busy are advisory to decode, the file never refuses a write.
module reg_file_scoreboard
    import reg_file_scoreboard_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int N_RD     = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [N_RD-1:0]          rd_en,
    input  logic [N_RD*ADDR_W-1:0]   rd_addr,
    output logic [N_RD*DATA_W-1:0]   rd_data,
    output logic [N_RD-1:0]          rd_busy,
    output logic                     stall,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_addr,
    output logic                     issue_waw,
    input  logic                     flush,
    output logic [ADDR_W:0]          pending_cnt
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0]  mem [NREG];
    logic [NREG-1:0]    pending;
    logic               wr_ok;

    assign wr_ok = wr_en && writable(32'(wr_addr), ZERO_REG != 0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    for (genvar i = 0; i < N_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              fwd;
        logic              zero_hit;

        assign ra       = rd_addr[i*ADDR_W +: ADDR_W];
        assign fwd      = (BYPASS != 0) && wr_ok && (wr_addr == ra);
        assign zero_hit = (ZERO_REG != 0) && (ra == '0);

        // Reset forces outputs low immediately, including any forwarded write data.
        assign rd_data[i*DATA_W +: DATA_W] =
            (reset || !rd_en[i] || zero_hit) ? '0 :
            fwd                              ? wr_data :
                                               mem[ra];
        assign rd_busy[i] = !reset && rd_en[i] && pending[ra] && !fwd;
    end

    assign stall = |rd_busy;

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .issue_en    (issue_en),
        .issue_addr  (issue_addr),
        .flush       (flush),
        .pending     (pending),
        .pending_cnt (pending_cnt),
        .issue_waw   (issue_waw)
    );

endmodule
